sram_fifo_ctrl: RTL

//  Valid/ready FIFO controller that owns one 1-write/1-read SRAM macro (active-low enables, 1-cycle read latency).

---
 rtl/sram_fifo_ctrl_pkg.sv | 15 +
 rtl/sram_fifo_skid.sv | 69 ++++++
 rtl/sram_fifo_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/sram_fifo_ctrl_pkg.sv
// rtl/sram_fifo_ctrl_pkg.sv - shared constants and helpers for the SRAM-backed FIFO
package sram_fifo_ctrl_pkg;

  localparam int SRAM_RD_LAT = 1;

  // Wraps at depth rather than at the address width, so depth need not be a power of two.
  function automatic int ptr_next(input int p, input int depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

  function automatic int lvl_width(input int depth);
    return $clog2(depth + 3);
  endfunction

endpackage

// File: rtl/sram_fifo_skid.sv
// rtl/sram_fifo_skid.sv - 2-entry output buffer that lands SRAM read data
// Entry 0 is always the head; a pop shifts entry 1 down.
module sram_fifo_skid #(
  parameter int WWORD = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             wr_valid,
  input  logic [WWORD-1:0] wr_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WWORD-1:0] out_data,
  output logic [1:0]       cnt
);

  logic [WWORD-1:0] ent0_q, ent0_d;
  logic [WWORD-1:0] ent1_q, ent1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             pop;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = ent0_q;
  assign cnt       = cnt_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = 2'd0;
    end else begin
      case ({wr_valid, pop})
        2'b01: begin
          ent0_d = ent1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) ent0_d = wr_data;
          else               ent1_d = wr_data;
          cnt_d = cnt_q + 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent0_d = wr_data;
          end else begin
            ent0_d = ent1_q;
            ent1_d = wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - valid/ready FIFO controller around a 1R/1W SRAM macro
// Pointers, occupancy counters and read issue live here; read data lands in sram_fifo_skid.
module sram_fifo_ctrl
  import sram_fifo_ctrl_pkg::*;
#(
  parameter int WWORD = 32,
  parameter int WADDR = 5,
  parameter int DEPTH = 24,
  parameter int WLVL  = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WWORD-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WWORD-1:0] out_data,
  output logic [WLVL-1:0]  level,
  output logic [WADDR-1:0] sram_ab,
  output logic [WWORD-1:0] sram_db,
  output logic             sram_cenb,
  output logic [WADDR-1:0] sram_aa,
  output logic             sram_cena,
  input  logic [WWORD-1:0] sram_qa
);

  localparam logic [WADDR:0] DEPTH_CNT = (WADDR+1)'(DEPTH);

  logic [WADDR-1:0] wptr_q, wptr_d;
  logic [WADDR-1:0] rptr_q, rptr_d;
  logic [WADDR:0]   mem_cnt_q, mem_cnt_d;
  logic             rd_inflight_q, rd_inflight_d;
  logic             in_ready_q, in_ready_d;
  logic [WLVL-1:0]  level_q, level_d;

  logic             push, pop, rd;
  logic [1:0]       skid_cnt;
  logic [2:0]       occ;
  logic             skid_wr;

  // occ is what the skid will hold once everything already requested has landed.
  always_comb begin
    push = in_valid & in_ready_q & ~clr;
    pop  = out_valid & out_ready & ~clr;
    occ  = {1'b0, skid_cnt} + {2'b00, rd_inflight_q} - {2'b00, pop};
    rd   = ~clr & (mem_cnt_q != '0) & (occ < 3'd2);
  end

  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    mem_cnt_d     = mem_cnt_q;
    rd_inflight_d = rd_inflight_q;
    level_d       = level_q;
    in_ready_d    = in_ready_q;
    if (clr) begin
      wptr_d        = '0;
      rptr_d        = '0;
      mem_cnt_d     = '0;
      rd_inflight_d = 1'b0;
      level_d       = '0;
      in_ready_d    = 1'b1;
    end else begin
      if (push) wptr_d = WADDR'(ptr_next(int'(wptr_q), DEPTH));
      if (rd)   rptr_d = WADDR'(ptr_next(int'(rptr_q), DEPTH));
      mem_cnt_d     = mem_cnt_q + (WADDR+1)'(push) - (WADDR+1)'(rd);
      rd_inflight_d = rd;
      level_d       = level_q + WLVL'(push) - WLVL'(pop);
      in_ready_d    = (mem_cnt_d < DEPTH_CNT);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      level_q       <= '0;
      in_ready_q    <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      level_q       <= level_d;
      in_ready_q    <= in_ready_d;
    end
  end

  // A read killed by clr still returns qa; it simply is not written into the skid.
  assign skid_wr = rd_inflight_q & ~clr;

  sram_fifo_skid #(
    .WWORD(WWORD)
  ) u_skid (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .wr_valid (skid_wr),
    .wr_data  (sram_qa),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .cnt      (skid_cnt)
  );

  assign in_ready  = in_ready_q;
  assign level     = level_q;
  assign sram_ab   = wptr_q;
  assign sram_db   = in_data;
  assign sram_cenb = ~push;
  assign sram_aa   = rptr_q;
  assign sram_cena = ~rd;

endmodule
